// File: rtl/serial_sub_unit.sv
// Multi-cycle subtractor: {bout,diff} = a - b - bin, DIGIT bits per clock with the
// borrow carried between cycles; valid/ready on both sides, zero and signed-overflow flags.
module serial_sub_unit #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_r;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] diff_sh_r;
  logic             br_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] diff_r;
  logic             bout_r;
  logic             ovf_r;
  logic             zero_r;
  logic             out_valid_r;

  logic [DIGIT-1:0] dig_s;
  logic             br_v_s;
  logic             br_msb_s;
  logic             br_out_s;
  logic [WIDTH-1:0] diff_nxt_s;

  // Full-subtractor chain over the current digit; br_msb_s is the borrow into its top bit
  always_comb begin
    dig_s    = {DIGIT{1'b0}};
    br_v_s   = br_r;
    br_msb_s = 1'b0;
    for (int i = 0; i < DIGIT; i++) begin
      br_msb_s = br_v_s;
      dig_s[i] = a_sh_r[i] ^ b_sh_r[i] ^ br_v_s;
      br_v_s   = (~a_sh_r[i] & b_sh_r[i]) | (~(a_sh_r[i] ^ b_sh_r[i]) & br_v_s);
    end
    br_out_s   = br_v_s;
    // New digit enters from the MSB side so after N digits the result is aligned
    diff_nxt_s = (diff_sh_r >> DIGIT) | (WIDTH'(dig_s) << (WIDTH - DIGIT));
  end

  // Control FSM, operand shifters and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      a_sh_r      <= {WIDTH{1'b0}};
      b_sh_r      <= {WIDTH{1'b0}};
      diff_sh_r   <= {WIDTH{1'b0}};
      br_r        <= 1'b0;
      cnt_r       <= {CW{1'b0}};
      diff_r      <= {WIDTH{1'b0}};
      bout_r      <= 1'b0;
      ovf_r       <= 1'b0;
      zero_r      <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_sh_r  <= a;
            b_sh_r  <= b;
            br_r    <= bin;
            cnt_r   <= {CW{1'b0}};
            state_r <= RUN;
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          a_sh_r    <= a_sh_r >> DIGIT;
          b_sh_r    <= b_sh_r >> DIGIT;
          br_r      <= br_out_s;
          diff_sh_r <= diff_nxt_s;
          cnt_r     <= cnt_r + CW'(1);
          if (cnt_r == CW'(N - 1)) begin
            state_r     <= DONE;
            out_valid_r <= 1'b1;
            diff_r      <= diff_nxt_s;
            bout_r      <= br_out_s;
            ovf_r       <= br_msb_s ^ br_out_s;
            zero_r      <= (diff_nxt_s == {WIDTH{1'b0}});
          end else begin
            state_r <= RUN;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            state_r     <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r     <= IDLE;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = (state_r == IDLE) & ~rst;
  assign out_valid = out_valid_r;
  assign diff      = diff_r;
  assign bout      = bout_r;
  assign ovf       = ovf_r;
  assign zero      = zero_r;

endmodule

// File: tb/tb_serial_sub_unit.sv
// Directed vector table and corner sequences on an 8/2 unit, plus random ops on
// 8/1, 8/8, 16/4 and 32/8 units checked against an arithmetic reference.
module tb_serial_sub_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       sw_rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       bin;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] diff;
  logic       bout;
  logic       ovf;
  logic       zero;

  int n_vec   = 0;
  int n_bad   = 0;
  int sw_done = 0;

  always #5 clk = ~clk;

  serial_sub_unit #(.WIDTH(8), .DIGIT(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout), .ovf(ovf), .zero(zero)
  );

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic int sw_w(input int g);
    case (g)
      0:       return 8;
      1:       return 8;
      2:       return 16;
      default: return 32;
    endcase
  endfunction

  function automatic int sw_d(input int g);
    case (g)
      0:       return 1;
      1:       return 8;
      2:       return 4;
      default: return 8;
    endcase
  endfunction

  // Random sweep across other parameterisations, each on its own reset
  for (genvar g = 0; g < 4; g++) begin : sw
    localparam int W = sw_w(g);
    localparam int D = sw_d(g);
    logic         iv, ir, ov, ordy, bi, bo, of, zr;
    logic [W-1:0] aa, bb, dd;

    serial_sub_unit #(.WIDTH(W), .DIGIT(D)) u (
      .clk(clk), .rst(sw_rst), .in_valid(iv), .in_ready(ir),
      .a(aa), .b(bb), .bin(bi), .out_valid(ov), .out_ready(ordy),
      .diff(dd), .bout(bo), .ovf(of), .zero(zr)
    );

    initial begin
      logic [W:0] r;
      logic       e_ovf;
      int         lat;
      iv = 1'b0; ordy = 1'b0; aa = '0; bb = '0; bi = 1'b0;
      @(negedge sw_rst);
      for (int k = 0; k < 150; k++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        @(negedge clk);
        aa = W'($urandom); bb = W'($urandom); bi = 1'($urandom);
        iv = 1'b1;
        chk($sformatf("sw%0d_ready", g), 64'(ir), 64'(1));
        @(posedge clk); #1; iv = 1'b0;
        r     = {1'b0, aa} - {1'b0, bb} - (W+1)'(bi);
        e_ovf = (aa[W-1] != bb[W-1]) && (r[W-1] != aa[W-1]);
        lat   = 0;
        while (!ov && lat < 40) begin
          @(posedge clk); #1; lat++;
        end
        chk($sformatf("sw%0d_latency", g), 64'(lat), 64'(W / D));
        chk($sformatf("sw%0d_result", g), 64'({bo, of, zr, dd}),
            64'({r[W], e_ovf, (r[W-1:0] == '0), r[W-1:0]}));
        repeat ($urandom_range(0, 3)) @(negedge clk);
        @(negedge clk); ordy = 1'b1;
        @(posedge clk); #1; ordy = 1'b0;
        chk($sformatf("sw%0d_release", g), 64'(ov), 64'(0));
      end
      sw_done++;
    end
  end

  typedef struct {
    logic [7:0] va;
    logic [7:0] vb;
    logic       vbin;
    logic [7:0] e_diff;
    logic       e_bout;
    logic       e_ovf;
    logic       e_zero;
  } vec_t;

  vec_t vecs [12];

  task automatic launch(input logic [7:0] ta, input logic [7:0] tb_, input logic tbin);
    @(negedge clk);
    a = ta; b = tb_; bin = tbin; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Counts edges from accept until out_valid; also flags any change of diff meanwhile
  task automatic wait_res(output int lat, output logic hold_ok);
    logic [7:0] prev;
    prev    = diff;
    lat     = 0;
    hold_ok = 1'b1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
      if (!out_valid && diff !== prev) hold_ok = 1'b0;
    end
  endtask

  task automatic handshake();
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  initial begin
    int         lat;
    logic       hold_ok;
    logic [7:0] t;
    vecs[0]  = '{8'h50, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{8'h05, 8'h04, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[5]  = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{8'h80, 8'h00, 1'b1, 8'h7F, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; sw_rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; a = 8'h00; b = 8'h00; bin = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_state", 64'({in_ready, out_valid, bout, ovf, zero, diff}), 64'(0));
    rst = 1'b0; sw_rst = 1'b0;
    #1;
    chk("ready_after_reset", 64'(in_ready), 64'(1));

    for (int i = 0; i < 12; i++) begin
      launch(vecs[i].va, vecs[i].vb, vecs[i].vbin);
      wait_res(lat, hold_ok);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(4));
      chk($sformatf("vec%0d_hold", i), 64'(hold_ok), 64'(1));
      chk($sformatf("vec%0d_result", i), 64'({bout, ovf, zero, diff}),
          64'({vecs[i].e_bout, vecs[i].e_ovf, vecs[i].e_zero, vecs[i].e_diff}));
      handshake();
    end

    // Backpressure: result held, new operand ignored until released
    launch(8'h50, 8'h20, 1'b0);
    wait_res(lat, hold_ok);
    chk("bp_latency", 64'(lat), 64'(4));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a = 8'h33; b = 8'h11; bin = 1'b0; in_valid = 1'b1;
      chk($sformatf("bp_hold%0d", i),
          64'({out_valid, in_ready, bout, ovf, zero, diff}), 64'({1'b1, 1'b0, 3'b000, 8'h30}));
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    chk("bp_release", 64'({out_valid, in_ready, diff}), 64'({1'b0, 1'b1, 8'h30}));
    @(posedge clk); #1; in_valid = 1'b0;
    wait_res(lat, hold_ok);
    chk("bp_next_latency", 64'(lat), 64'(4));
    chk("bp_next_result", 64'({bout, ovf, zero, diff}), 64'({3'b000, 8'h22}));
    handshake();

    // Reset for one cycle with count==2
    launch(8'h50, 8'h20, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk); rst = 1'b1;
    #1;
    chk("rst_mid_run", 64'({out_valid, in_ready, diff}), 64'(0));
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_release", 64'({out_valid, in_ready, diff}), 64'({1'b0, 1'b1, 8'h00}));
    t = 8'h10;
    launch(t, 8'h01, 1'b0);
    wait_res(lat, hold_ok);
    chk("rst_next_latency", 64'(lat), 64'(4));
    chk("rst_next_result", 64'({bout, ovf, zero, diff}), 64'({3'b000, 8'h0F}));
    handshake();
    chk("result_kept", 64'({out_valid, diff}), 64'({1'b0, 8'h0F}));

    for (int i = 0; i < 60000 && sw_done < 4; i++) @(posedge clk);
    chk("sweep_done", 64'(sw_done), 64'(4));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
